// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES equal segments with valid/ready flow control.
// Optional signed-overflow output is enabled by defining ADDER_OVF_EN.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];

    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_c_nx;
    logic [WIDTH-1:0]  w_a_in [STAGES];
    logic [WIDTH-1:0]  w_b_in [STAGES];
    logic [WIDTH-1:0]  w_s_in [STAGES];
    logic [WIDTH-1:0]  w_s_nx [STAGES];
    logic              w_full;

    // Adds segment k of the operands and splices it into the partial sum; returns {carry, sum}.
    function automatic logic [WIDTH:0] seg_add(
        input logic [WIDTH-1:0] pa,
        input logic [WIDTH-1:0] pb,
        input logic [WIDTH-1:0] ps,
        input logic             c,
        input int               k
    );
        logic [SEG:0]     t;
        logic [WIDTH-1:0] s;
        t = {1'b0, pa[k*SEG +: SEG]} + {1'b0, pb[k*SEG +: SEG]} + {{SEG{1'b0}}, c};
        s = ps;
        s[k*SEG +: SEG] = t[SEG-1:0];
        return {t[SEG], s};
    endfunction

    // Stage inputs come from the ports for stage 0 and from the previous stage otherwise.
    always_comb begin
        w_v_in    = {STAGES{1'b0}};
        w_c_in    = {STAGES{1'b0}};
        w_c_nx    = {STAGES{1'b0}};
        w_v_in[0] = in_valid;
        w_c_in[0] = cin;
        w_a_in[0] = a;
        w_b_in[0] = b;
        w_s_in[0] = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k] = r_v[k-1];
            w_c_in[k] = r_c[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            {w_c_nx[k], w_s_nx[k]} = seg_add(w_a_in[k], w_b_in[k], w_s_in[k], w_c_in[k], k);
        end
    end

    // A stage may load unless it and every stage after it are full while the consumer stalls.
    always_comb begin
        w_load = {STAGES{1'b0}};
        w_full = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            w_full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                w_full = w_full & r_v[j];
            end
            w_load[k] = out_ready | ~w_full;
        end
    end

    // Pipeline registers; data regs of empty stages carry don't-care values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= {STAGES{1'b0}};
            r_c <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= {WIDTH{1'b0}};
                r_b[k] <= {WIDTH{1'b0}};
                r_s[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_v_in[k];
                    r_c[k] <= w_c_nx[k];
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_s[k] <= w_s_nx[k];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];

`ifdef ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf_nx;

    assign w_ovf_nx = (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1]) &
                      (w_s_nx[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);

    // Overflow travels with the final stage so it stays aligned with sum during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_load[LAST]) begin
            r_ovf <= w_ovf_nx;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
